// File: rtl/jk_ctrl_pkg.sv
// Shared encodings for the JK bank sequencing controller:
// command opcodes carried on CMD_OP and the controller FSM states.
package jk_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_LOAD = 2'b01,
        OP_UP   = 2'b10,
        OP_DOWN = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/jk_excite.sv
// Minimal JK excitation: per bit, drive J/K so a JK flop holding q captures d
// on the next edge, leaving the unused input at 0.
module jk_excite #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    // q=0: set only if d=1; q=1: reset only if d=0.
    assign j = ~q & d;
    assign k =  q & ~d;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Sequencing controller for an external bank of JK flops holding a modulo-MOD
// count: accepts load/up/down/hold commands and tracks the count in a shadow.
module jk_seq_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [WIDTH-1:0] CMD_ARG,
    input  logic [WIDTH-1:0] Q_IN,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             BUSY,
    output logic             DONE,
    output logic             TC,
    output logic             ERR
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    // Handshake: a command transfers on a rising CLK edge where CMD_VALID and
    // CMD_READY are both high; CMD_OP/CMD_ARG are captured on that edge.
    // CMD_READY is high only in IDLE, and an offer that is not taken is dropped.

    state_t           state;
    state_t           state_n;
    op_t              op_r;
    logic [WIDTH-1:0] arg_r;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] remaining;

    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic             tc_r;
    logic             err_r;

    logic             accept;
    logic             step_up;
    logic             at_top;
    logic             at_bot;
    logic             wrap;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] target;
    logic             drive_en;
    logic [WIDTH-1:0] j_raw;
    logic [WIDTH-1:0] k_raw;

    assign accept = CMD_VALID & ready_r;

    // Next count is derived from the shadow only, so a misbehaving bank
    // cannot disturb the sequence; limits are tested before stepping.
    always_comb begin
        step_up  = (op_r == OP_UP);
        at_top   = (shadow == MAX_VAL);
        at_bot   = (shadow == '0);
        wrap     = step_up ? at_top : at_bot;
        step_val = shadow;
        if (step_up) begin
            step_val = at_top ? '0 : shadow + 1'b1;
        end else begin
            step_val = at_bot ? MAX_VAL : shadow - 1'b1;
        end
        load_val = (arg_r > MAX_VAL) ? MAX_VAL : arg_r;
    end

    always_comb begin
        target   = Q_IN;
        drive_en = 1'b0;
        case (state)
            S_LOAD: begin
                target   = load_val;
                drive_en = 1'b1;
            end
            S_RUN: begin
                target   = step_val;
                drive_en = 1'b1;
            end
            default: begin
                target   = Q_IN;
                drive_en = 1'b0;
            end
        endcase
    end

    jk_excite #(
        .WIDTH(WIDTH)
    ) u_excite (
        .q(Q_IN),
        .d(target),
        .j(j_raw),
        .k(k_raw)
    );

    assign J = drive_en ? j_raw : '0;
    assign K = drive_en ? k_raw : '0;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op_t'(CMD_OP))
                        OP_LOAD: state_n = S_LOAD;
                        OP_UP,
                        OP_DOWN: state_n = (CMD_ARG != '0) ? S_RUN : S_DONE;
                        default: state_n = S_DONE;
                    endcase
                end
            end
            S_LOAD:  state_n = S_DONE;
            S_RUN:   state_n = (remaining == WIDTH'(1)) ? S_DONE : S_RUN;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state     <= S_IDLE;
            op_r      <= OP_HOLD;
            arg_r     <= '0;
            shadow    <= '0;
            remaining <= '0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            tc_r      <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state   <= state_n;
            ready_r <= (state_n == S_IDLE);
            busy_r  <= (state_n == S_LOAD) || (state_n == S_RUN);
            done_r  <= (state_n == S_DONE);
            tc_r    <= (state == S_RUN) && wrap;

            if (accept) begin
                op_r      <= op_t'(CMD_OP);
                arg_r     <= CMD_ARG;
                remaining <= CMD_ARG;
            end

            case (state)
                S_LOAD: begin
                    shadow <= load_val;
                    err_r  <= 1'b0;
                end
                S_RUN: begin
                    shadow    <= step_val;
                    remaining <= remaining - 1'b1;
                end
                S_DONE: begin
                    if (Q_IN != shadow) begin
                        err_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign CMD_READY = ready_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign TC        = tc_r;
    assign ERR       = err_r;

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Bench for jk_seq_ctrl: a JK flop bank model on CLK, a per-cycle expected
// queue built from a reference count model, and directed plus random commands.
module tb_jk_seq_ctrl;
    import jk_ctrl_pkg::*;

    localparam int W = 4;
    localparam int M = 10;
    localparam logic [W-1:0] MAXV = W'(M - 1);

    logic         CLK = 1'b0;
    logic         CLR;
    logic         CMD_VALID;
    logic         CMD_READY;
    logic [1:0]   CMD_OP;
    logic [W-1:0] CMD_ARG;
    logic [W-1:0] Q_IN;
    logic [W-1:0] J;
    logic [W-1:0] K;
    logic         BUSY;
    logic         DONE;
    logic         TC;
    logic         ERR;

    logic [W-1:0] bank = 4'b0101;
    logic         stuck = 1'b0;

    // Entry layout: {done, tc, j, k, q}, one entry per cycle after accept.
    logic [3*W+1:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] m_shadow;
    logic [W-1:0] m_bank;
    logic         m_err;

    jk_seq_ctrl #(
        .WIDTH(W),
        .MOD(M)
    ) dut (
        .CLK(CLK),
        .CLR(CLR),
        .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP),
        .CMD_ARG(CMD_ARG),
        .Q_IN(Q_IN),
        .J(J),
        .K(K),
        .BUSY(BUSY),
        .DONE(DONE),
        .TC(TC),
        .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    assign Q_IN = bank;

    always @(posedge CLK) begin : bank_model
        logic [W-1:0] nb;
        nb = (J & ~bank) | (~K & bank);
        if (stuck) nb[0] = 1'b0;
        bank <= nb;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] arg);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_ARG   = arg;
        check("ready_before_accept", {31'b0, CMD_READY}, 32'd1);
        @(negedge CLK);
        CMD_VALID = 1'b0;
        CMD_OP    = $urandom_range(0, 3);
        CMD_ARG   = $urandom_range(0, 15);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] arg);
        logic [W-1:0]   bq[16];
        logic [W-1:0]   tg[16];
        logic           tq[16];
        logic [W-1:0]   mask;
        logic [W-1:0]   jj;
        logic [W-1:0]   kk;
        logic           up;
        logic           wrap;
        logic           dn;
        logic [3*W+1:0] e;
        int             len;

        mask  = {{(W-1){1'b0}}, stuck};
        bq[0] = m_bank;
        tq[0] = 1'b0;
        tg[0] = m_bank;
        len   = 1;
        if (op == OP_LOAD) begin
            m_shadow = (arg > MAXV) ? MAXV : arg;
            tg[0]    = m_shadow;
            m_bank   = m_shadow & ~mask;
            bq[1]    = m_bank;
            tq[1]    = 1'b0;
            len      = 2;
            m_err    = (m_bank != m_shadow);
        end else begin
            if ((op == OP_UP || op == OP_DOWN) && arg != '0) begin
                up = (op == OP_UP);
                for (int i = 1; i <= int'(arg); i++) begin
                    wrap = up ? (m_shadow == MAXV) : (m_shadow == '0);
                    if (up) m_shadow = wrap ? '0 : m_shadow + 1'b1;
                    else    m_shadow = wrap ? MAXV : m_shadow - 1'b1;
                    tg[i-1] = m_shadow;
                    m_bank  = m_shadow & ~mask;
                    bq[i]   = m_bank;
                    tq[i]   = wrap;
                end
                len = int'(arg) + 1;
            end
            m_err = m_err | (m_bank != m_shadow);
        end

        for (int k = 0; k < len; k++) begin
            dn = (k == len - 1);
            jj = dn ? '0 : (~bq[k] & tg[k]);
            kk = dn ? '0 : (bq[k] & ~tg[k]);
            exp_q.push_back({dn, tq[k], jj, kk, bq[k]});
        end

        send(op, arg);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("q",    {28'b0, Q_IN}, {28'b0, e[W-1:0]});
            check("k",    {28'b0, K},    {28'b0, e[2*W-1:W]});
            check("j",    {28'b0, J},    {28'b0, e[3*W-1:2*W]});
            check("tc",   {31'b0, TC},   {31'b0, e[3*W]});
            check("done", {31'b0, DONE}, {31'b0, e[3*W+1]});
            check("busy", {31'b0, BUSY}, {31'b0, ~e[3*W+1]});
            if (exp_q.size() > 0) @(negedge CLK);
        end
        @(negedge CLK);
        check("ready_after_done", {31'b0, CMD_READY}, 32'd1);
        check("idle_busy",        {31'b0, BUSY},      32'd0);
        check("idle_done",        {31'b0, DONE},      32'd0);
        check("err",              {31'b0, ERR},       {31'b0, m_err});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [1:0]   rop;
        logic [W-1:0] rarg;

        CLR       = 1'b1;
        CMD_VALID = 1'b0;
        CMD_OP    = 2'b00;
        CMD_ARG   = '0;
        m_shadow  = '0;
        m_bank    = 4'b0101;
        m_err     = 1'b0;

        repeat (2) @(negedge CLK);
        check("rst_ready", {31'b0, CMD_READY}, 32'd1);
        check("rst_busy",  {31'b0, BUSY},      32'd0);
        check("rst_done",  {31'b0, DONE},      32'd0);
        check("rst_tc",    {31'b0, TC},        32'd0);
        check("rst_err",   {31'b0, ERR},       32'd0);
        check("rst_j",     {28'b0, J},         32'd0);
        check("rst_k",     {28'b0, K},         32'd0);
        check("rst_bank",  {28'b0, Q_IN},      32'd5);
        CLR = 1'b0;
        @(negedge CLK);

        // Directed: load from 0101, wrap up, wrap down, clamp, zero-step.
        run_cmd(OP_LOAD, 4'd7);
        run_cmd(OP_LOAD, 4'd8);
        run_cmd(OP_UP,   4'd3);
        run_cmd(OP_LOAD, 4'd1);
        run_cmd(OP_DOWN, 4'd2);
        run_cmd(OP_LOAD, 4'd12);
        run_cmd(OP_UP,   4'd0);

        // Abort UP 5 after its third step with CLR.
        send(OP_UP, 4'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            m_shadow = (m_shadow == MAXV) ? '0 : m_shadow + 1'b1;
            m_bank   = m_shadow;
            check("abort_step_q", {28'b0, Q_IN}, {28'b0, m_bank});
        end
        CLR = 1'b1;
        #1;
        check("abort_j",     {28'b0, J},         32'd0);
        check("abort_k",     {28'b0, K},         32'd0);
        check("abort_busy",  {31'b0, BUSY},      32'd0);
        check("abort_done",  {31'b0, DONE},      32'd0);
        check("abort_ready", {31'b0, CMD_READY}, 32'd1);
        @(negedge CLK);
        CLR = 1'b0;
        @(negedge CLK);
        check("abort_bank_hold", {28'b0, Q_IN},      {28'b0, m_bank});
        check("abort_ready_rel", {31'b0, CMD_READY}, 32'd1);
        check("abort_no_done",   {31'b0, DONE},      32'd0);
        check("abort_idle_busy", {31'b0, BUSY},      32'd0);
        m_shadow = '0;
        m_err    = 1'b0;

        // Bank bit0 stuck at 0: ERR sets, survives HOLD, clears on clean LOAD.
        stuck = 1'b1;
        run_cmd(OP_LOAD, 4'd3);
        run_cmd(OP_HOLD, 4'd0);
        stuck = 1'b0;
        run_cmd(OP_LOAD, 4'd2);

        for (int i = 0; i < 8; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rarg = (rop == OP_LOAD) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 6));
            run_cmd(rop, rarg);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
